// File: rtl/processor_memory_arbiter.sv
// Arbiter sharing the single-port data RAM between the processor stage-2 port and a host port.
// Optional starvation guard: define ARBITER_STARVATION_GUARD_EN to build wait_cnt and the cpu_stall pulse.

// Property checks on the arbiter's grant and stall behaviour.
module processor_memory_arbiter_chk #(
  parameter int MAX_WAIT = 15
) (
  input logic clock,
  input logic reset,
  input logic cpu_req,
  input logic cpu_stall,
  input logic host_valid,
  input logic host_ready,
  input logic mem_write_enable
);

  a_max_wait_range: assert property (@(posedge clock) disable iff (reset)
    (MAX_WAIT >= 1) && (MAX_WAIT <= 255));

  a_cpu_priority: assert property (@(posedge clock) disable iff (reset)
    host_ready |-> !(cpu_req && !cpu_stall));

  a_ready_needs_valid: assert property (@(posedge clock) disable iff (reset)
    host_ready |-> host_valid);

  a_stall_serves_host: assert property (@(posedge clock) disable iff (reset)
    (cpu_stall && host_valid) |-> host_ready);

  a_stall_one_cycle: assert property (@(posedge clock) disable iff (reset)
    cpu_stall |=> !cpu_stall);

  a_no_write_in_reset: assert property (@(posedge clock)
    reset |-> !mem_write_enable);

endmodule

module processor_memory_arbiter #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int MAX_WAIT  = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 host_valid,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_ready,
  output logic                 host_rdata_valid,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_write_enable,
  output logic [WORD_SIZE-1:0] mem_in,
  input  logic [WORD_SIZE-1:0] mem_out
);

  logic grant_cpu_s;
  logic grant_host_s;
  logic host_rd_xfer_s;
  logic host_rdata_valid_q;
  logic host_rdata_valid_d;

  // Processor wins unless the guard is stalling it; host takes any cycle the processor leaves free.
  always_comb begin
    grant_cpu_s    = cpu_req && !cpu_stall;
    grant_host_s   = host_valid && !grant_cpu_s;
    host_rd_xfer_s = grant_host_s && !host_we;
  end

  // RAM port mux; the write strobe is gated by reset so nothing lands while state is being cleared.
  always_comb begin
    if (grant_host_s) begin
      mem_addr = host_addr;
      mem_in   = host_wdata;
    end else begin
      mem_addr = cpu_addr;
      mem_in   = cpu_wdata;
    end
    mem_write_enable = !reset && ((grant_cpu_s && cpu_we) || (grant_host_s && host_we));
  end

  // Both requesters see the RAM read port directly; the RAM supplies the one-cycle latency.
  always_comb begin
    cpu_rdata  = mem_out;
    host_rdata = mem_out;
    host_ready = grant_host_s;
  end

  // A host read accepted this cycle has its data on mem_out next cycle.
  always_comb begin
    host_rdata_valid_d = host_rd_xfer_s;
  end

  // Read-valid flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      host_rdata_valid_q <= 1'b0;
    end else begin
      host_rdata_valid_q <= host_rdata_valid_d;
    end
  end

  assign host_rdata_valid = host_rdata_valid_q;

`ifdef ARBITER_STARVATION_GUARD_EN
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(32'd1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(32'd0);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic              cpu_stall_q;
  logic              cpu_stall_d;

  // Count cycles the host spends refused; reaching MAX_WAIT schedules a one-cycle processor stall.
  always_comb begin
    if (!host_valid || grant_host_s) begin
      wait_cnt_d = WAIT_ZERO;
    end else if (wait_cnt_q == WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = wait_cnt_q + WAIT_ONE;
    end
    cpu_stall_d = (wait_cnt_d == WAIT_MAX);
  end

  // Starvation guard state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q  <= WAIT_ZERO;
      cpu_stall_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      cpu_stall_q <= cpu_stall_d;
    end
  end

  assign cpu_stall = cpu_stall_q;
`else
  assign cpu_stall = 1'b0;
`endif

  processor_memory_arbiter_chk #(
    .MAX_WAIT (MAX_WAIT)
  ) u_chk (
    .clock            (clock),
    .reset            (reset),
    .cpu_req          (cpu_req),
    .cpu_stall        (cpu_stall),
    .host_valid       (host_valid),
    .host_ready       (host_ready),
    .mem_write_enable (mem_write_enable)
  );

endmodule

// File: tb/tb_processor_memory_arbiter.sv
// Directed bench for processor_memory_arbiter: vector table plus multi-cycle reset and starvation sequences.
// Guard-specific sequences follow ARBITER_STARVATION_GUARD_EN as the RTL does.
module tb_processor_memory_arbiter;

  typedef struct {
    logic        creq;
    logic        cwe;
    logic [17:0] caddr;
    logic [17:0] cwd;
    logic        hv;
    logic        hwe;
    logic [17:0] haddr;
    logic [17:0] hwd;
    logic        e_hr;
    logic        e_we;
    logic [17:0] e_addr;
    logic [17:0] e_in;
    logic        e_rdv;
    logic        chk_rd;
    logic [17:0] e_rd;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [17:0] cpu_addr;
  logic [17:0] cpu_wdata;
  logic [17:0] cpu_rdata;
  logic        cpu_stall;
  logic        host_valid;
  logic        host_we;
  logic [17:0] host_addr;
  logic [17:0] host_wdata;
  logic        host_ready;
  logic        host_rdata_valid;
  logic [17:0] host_rdata;
  logic [17:0] mem_addr;
  logic        mem_write_enable;
  logic [17:0] mem_in;
  logic [17:0] mem_out;

  logic [17:0] ram [0:1023];

  int n_pass;
  int n_total;

  processor_memory_arbiter #(
    .ADDR_SIZE (18),
    .WORD_SIZE (18),
    .MAX_WAIT  (3)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_rdata        (cpu_rdata),
    .cpu_stall        (cpu_stall),
    .host_valid       (host_valid),
    .host_we          (host_we),
    .host_addr        (host_addr),
    .host_wdata       (host_wdata),
    .host_ready       (host_ready),
    .host_rdata_valid (host_rdata_valid),
    .host_rdata       (host_rdata),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_in           (mem_in),
    .mem_out          (mem_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous single-port RAM with one-cycle read; a few words are preloaded during reset.
  always @(posedge clock) begin
    if (reset) begin
      ram[10'h010] <= 18'h2ABCD;
      ram[10'h020] <= 18'h11111;
      ram[10'h030] <= 18'h3C3C3;
    end else if (mem_write_enable) begin
      ram[mem_addr[9:0]] <= mem_in;
    end
    mem_out <= ram[mem_addr[9:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic creq, input logic cwe, input logic [17:0] caddr, input logic [17:0] cwd,
    input logic hv, input logic hwe, input logic [17:0] haddr, input logic [17:0] hwd,
    input logic e_hr, input logic e_we, input logic [17:0] e_addr, input logic [17:0] e_in,
    input logic e_rdv, input logic chk_rd, input logic [17:0] e_rd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.hv = hv; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
    v.e_hr = e_hr; v.e_we = e_we; v.e_addr = e_addr; v.e_in = e_in;
    v.e_rdv = e_rdv; v.chk_rd = chk_rd; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    cpu_req    = v.creq;
    cpu_we     = v.cwe;
    cpu_addr   = v.caddr;
    cpu_wdata  = v.cwd;
    host_valid = v.hv;
    host_we    = v.hwe;
    host_addr  = v.haddr;
    host_wdata = v.hwd;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 18'h0; cpu_wdata = 18'h0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = 18'h0; host_wdata = 18'h0;
  endtask

  vec_t vecs [14];
  logic run_hv    [12];
  logic run_stall [12];

  initial begin
    n_pass  = 0;
    n_total = 0;
    //              creq cwe  caddr    cwd       hv   hwe  haddr    hwd       e_hr e_we e_addr   e_in      rdv  chk  rdata
    vecs[0]  = mk(1'b0,1'b0,18'h000,18'h00000,1'b0,1'b0,18'h000,18'h00000,1'b0,1'b0,18'h000,18'h00000,1'b0,1'b0,18'h00000);
    vecs[1]  = mk(1'b0,1'b0,18'h333,18'h0AAAA,1'b1,1'b0,18'h010,18'h15555,1'b1,1'b0,18'h010,18'h15555,1'b0,1'b0,18'h00000);
    vecs[2]  = mk(1'b1,1'b0,18'h030,18'h00000,1'b0,1'b0,18'h000,18'h00000,1'b0,1'b0,18'h030,18'h00000,1'b1,1'b1,18'h2ABCD);
    vecs[3]  = mk(1'b1,1'b1,18'h100,18'h12345,1'b1,1'b1,18'h200,18'h0ABCD,1'b0,1'b1,18'h100,18'h12345,1'b0,1'b1,18'h3C3C3);
    vecs[4]  = mk(1'b0,1'b0,18'h044,18'h00000,1'b1,1'b1,18'h200,18'h0ABCD,1'b1,1'b1,18'h200,18'h0ABCD,1'b0,1'b0,18'h00000);
    vecs[5]  = mk(1'b0,1'b0,18'h000,18'h00000,1'b1,1'b0,18'h100,18'h00000,1'b1,1'b0,18'h100,18'h00000,1'b0,1'b0,18'h00000);
    vecs[6]  = mk(1'b0,1'b0,18'h000,18'h00000,1'b1,1'b0,18'h200,18'h00000,1'b1,1'b0,18'h200,18'h00000,1'b1,1'b1,18'h12345);
    vecs[7]  = mk(1'b1,1'b0,18'h010,18'h00000,1'b1,1'b0,18'h020,18'h00000,1'b0,1'b0,18'h010,18'h00000,1'b1,1'b1,18'h0ABCD);
    vecs[8]  = mk(1'b0,1'b0,18'h000,18'h00000,1'b0,1'b0,18'h000,18'h00000,1'b0,1'b0,18'h000,18'h00000,1'b0,1'b1,18'h2ABCD);
    vecs[9]  = mk(1'b0,1'b0,18'h000,18'h00000,1'b1,1'b0,18'h020,18'h00000,1'b1,1'b0,18'h020,18'h00000,1'b0,1'b0,18'h00000);
    vecs[10] = mk(1'b0,1'b0,18'h000,18'h00000,1'b0,1'b0,18'h000,18'h00000,1'b0,1'b0,18'h000,18'h00000,1'b1,1'b1,18'h11111);
    vecs[11] = mk(1'b1,1'b1,18'h030,18'h00777,1'b1,1'b0,18'h010,18'h00000,1'b0,1'b1,18'h030,18'h00777,1'b0,1'b0,18'h00000);
    vecs[12] = mk(1'b1,1'b0,18'h030,18'h00000,1'b0,1'b0,18'h000,18'h00000,1'b0,1'b0,18'h030,18'h00000,1'b0,1'b0,18'h00000);
    vecs[13] = mk(1'b0,1'b0,18'h000,18'h00000,1'b0,1'b0,18'h000,18'h00000,1'b0,1'b0,18'h000,18'h00000,1'b0,1'b1,18'h00777);

    // Reset state, with a host write pending to show the write strobe is held off.
    idle();
    reset = 1'b1;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 18'h050; host_wdata = 18'h00001;
    repeat (2) @(posedge clock);
    @(negedge clock); #3;
    chk("reset.cpu_stall", 32'(cpu_stall), 32'd0);
    chk("reset.host_rdata_valid", 32'(host_rdata_valid), 32'd0);
    chk("reset.mem_write_enable", 32'(mem_write_enable), 32'd0);
    chk("reset.mem_addr", 32'(mem_addr), 32'h050);
    @(negedge clock);
    idle();
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      drive(vecs[i]);
      #3;
      chk($sformatf("v%0d.host_ready", i), 32'(host_ready), 32'(vecs[i].e_hr));
      chk($sformatf("v%0d.mem_we", i), 32'(mem_write_enable), 32'(vecs[i].e_we));
      chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d.mem_in", i), 32'(mem_in), 32'(vecs[i].e_in));
      chk($sformatf("v%0d.cpu_stall", i), 32'(cpu_stall), 32'd0);
      chk($sformatf("v%0d.host_rdata_valid", i), 32'(host_rdata_valid), 32'(vecs[i].e_rdv));
      if (vecs[i].chk_rd) begin
        chk($sformatf("v%0d.host_rdata", i), 32'(host_rdata), 32'(vecs[i].e_rd));
        chk($sformatf("v%0d.cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_rd));
      end
    end

    // Reset arriving the cycle after a granted host read kills its read-valid pulse at once.
    @(negedge clock);
    idle();
    host_valid = 1'b1; host_addr = 18'h010;
    #3;
    chk("rstmid.host_ready", 32'(host_ready), 32'd1);
    @(posedge clock);
    #1;
    chk("rstmid.rdv_before", 32'(host_rdata_valid), 32'd1);
    host_we = 1'b1; host_addr = 18'h040; host_wdata = 18'h01234;
    reset = 1'b1;
    #1;
    chk("rstmid.host_rdata_valid", 32'(host_rdata_valid), 32'd0);
    chk("rstmid.mem_write_enable", 32'(mem_write_enable), 32'd0);
    chk("rstmid.cpu_stall", 32'(cpu_stall), 32'd0);
    @(negedge clock);
    idle();
    reset = 1'b0;
    @(negedge clock);

`ifdef ARBITER_STARVATION_GUARD_EN
    // Continuous cpu_req with a waiting host: forced grant in cycle 3, stall gone in cycle 4.
    idle();
    cpu_req = 1'b1; cpu_addr = 18'h030;
    host_valid = 1'b1; host_addr = 18'h020;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clock);
      #3;
      chk($sformatf("guard.c%0d.host_ready", c), 32'(host_ready), (c == 3) ? 32'd1 : 32'd0);
      chk($sformatf("guard.c%0d.cpu_stall", c), 32'(cpu_stall), (c == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    host_valid = 1'b0;

    // Drop at wait_cnt=2 restarts the count; later a stall cycle with host_valid low still lasts one cycle.
    run_hv    = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0};
    run_stall = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      host_valid = run_hv[c];
      #3;
      chk($sformatf("restart.c%0d.cpu_stall", c), 32'(cpu_stall), 32'(run_stall[c]));
      chk($sformatf("restart.c%0d.host_ready", c), 32'(host_ready),
          32'(run_stall[c] && run_hv[c]));
    end
`else
    // Without the guard, continuous cpu_req starves the host and never stalls.
    idle();
    cpu_req = 1'b1; cpu_addr = 18'h030;
    host_valid = 1'b1; host_addr = 18'h020;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      #3;
      chk($sformatf("starve.c%0d.host_ready", c), 32'(host_ready), 32'd0);
      chk($sformatf("starve.c%0d.cpu_stall", c), 32'(cpu_stall), 32'd0);
    end
    @(negedge clock);
    cpu_req = 1'b0;
    #3;
    chk("starve.release.host_ready", 32'(host_ready), 32'd1);
    chk("starve.release.mem_addr", 32'(mem_addr), 32'h020);
`endif

    @(negedge clock);
    idle();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/processor_memory_arbiter.md
# processor_memory_arbiter

Shares the single-port data memory between the processor's register/memory-read stage and a host (debug/DMA) port. The processor has priority; the host is served in cycles where the processor makes no memory request. An optional starvation guard stalls the processor pipeline for one cycle so a waiting host is always served. The block sits between stage 2's memory interface and the data RAM, which has a 1-cycle synchronous read.

## Interface
Parameters:
- ADDR_SIZE, 18, memory address width
- WORD_SIZE, 18, memory word width
- MAX_WAIT, 15, host wait cycles before a forced grant (1..255)

Ports:
- clock  in  1  single clock, all registers on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- cpu_req  in  1  processor needs memory this cycle (load, store, call push, return read)
- cpu_we  in  1  processor write
- cpu_addr  in  ADDR_SIZE  processor address
- cpu_wdata  in  WORD_SIZE  processor write data
- cpu_rdata  out  WORD_SIZE  read data, 1 cycle after the request
- cpu_stall  out  1  processor must hold its stage-2 instruction this cycle; drives waiting_global OR-in
- host_valid  in  1  host request pending
- host_we  in  1  host write
- host_addr  in  ADDR_SIZE  host address
- host_wdata  in  WORD_SIZE  host write data
- host_ready  out  1  host request accepted this cycle
- host_rdata_valid  out  1  host_rdata is valid this cycle
- host_rdata  out  WORD_SIZE  host read data
- mem_addr  out  ADDR_SIZE  RAM address
- mem_write_enable  out  1  RAM write strobe
- mem_in  out  WORD_SIZE  RAM write data
- mem_out  in  WORD_SIZE  RAM read data (address of previous cycle)

## Operation
- Grant is combinational each cycle:
  - grant_cpu = cpu_req && !cpu_stall
  - grant_host = host_valid && !grant_cpu
- Mux:
  - If grant_host, mem_* take the host_* values.
  - Otherwise mem_* take the cpu_* values.
  - mem_write_enable = (grant_cpu && cpu_we) || (grant_host && host_we); forced 0 while reset is high.
- host_ready = grant_host. A host transfer occurs on host_valid && host_ready.
- The host must hold host_* stable while host_valid is high and host_ready is low. The arbiter does not check this.
- cpu_rdata = mem_out, always (passthrough). host_rdata = mem_out, always (passthrough).
- host_rdata_valid register: set to 1 the cycle after a host read transfer (grant_host && !host_we); otherwise 0.
- A write transfer produces no host_rdata_valid pulse.
- wait_cnt register, width ceil(log2(MAX_WAIT+1)):
  - Increments while host_valid && !host_ready, saturating at MAX_WAIT.
  - Clears to 0 on a host transfer or when host_valid is low.
- Starvation guard (see Configuration): cpu_stall is a register, next value = (wait_cnt_next == MAX_WAIT).
  - While cpu_stall = 1, cpu_req is ignored, so the host is granted.
  - The handshake clears wait_cnt, so cpu_stall drops the following cycle. cpu_stall pulses for exactly one cycle.
  - If host_valid falls during a stall cycle, no transfer occurs. The stall still lasts exactly one cycle.

## Timing
- Reset values: cpu_stall = 0, host_rdata_valid = 0, wait_cnt = 0, mem_write_enable = 0.
  - mem_addr, mem_in, host_ready and the rdata outputs follow the combinational mux.
- Grant, mux and host_ready have zero latency (same cycle as the request).
- Read data returns 1 cycle after the address for both requesters.
- Simultaneous cpu_req and host_valid: cpu wins, unless cpu_stall = 1.
- Reset asserted mid-transfer: an in-flight host read loses its host_rdata_valid. The host must reissue the read.
- A back-to-back host stream with no cpu_req gives 1 transfer per cycle.

## Configuration
- ARBITER_STARVATION_GUARD_EN defined: wait_cnt and cpu_stall are implemented as described above.
- Not defined:
  - cpu_stall is tied to 0 and wait_cnt is absent.
  - The host is served only in cycles with cpu_req = 0; continuous cpu_req starves the host indefinitely.

## Test plan
- Idle CPU, host read addr 0x00010 holding 0x2ABCD → host_ready = 1 in cycle N; host_rdata_valid = 1 and host_rdata = 0x2ABCD in cycle N+1.
- cpu_req write addr 0x00100 data 0x12345 together with host_valid write addr 0x00200 → RAM gets 0x12345 at 0x00100 and host_ready = 0. Next cycle with cpu_req = 0, the host write lands at 0x00200.
- Guard enabled, MAX_WAIT = 3, cpu_req held high, host_valid high from cycle 0:
  - host_ready = 0 for cycles 0..2.
  - cpu_stall = 1 and host_ready = 1 in cycle 3.
  - cpu_stall = 0 in cycle 4.
- Guard disabled, same stimulus for 100 cycles → host_ready never 1, cpu_stall always 0.
- Host read granted in cycle N with reset asserted in cycle N+1 → host_rdata_valid = 0, mem_write_enable = 0, wait_cnt = 0 immediately.
- host_valid dropped at wait_cnt = 2 and reasserted (MAX_WAIT = 3, cpu_req high) → counting restarts from 0; stall occurs 3 cycles after reassertion.
